viterbi_channel_injector: RTL

//  Parametrised channel-impairment stage placed between the convolutional encoder and the Viterbi decoder.

---
 rtl/viterbi_channel_injector.sv | 117 +++++++++++
 1 files changed

// File: rtl/viterbi_channel_injector.sv
// Channel-impairment stage between convolutional encoder and Viterbi decoder: registers each coded
// symbol and flips bits in periodic bursts and/or LFSR-random slots. Random mode needs INJ_RANDOM_EN.
module viterbi_channel_injector #(
  parameter int unsigned SYM_W     = 2,
  parameter int unsigned CNT_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SYM_W-1:0] sym_i,
  input  logic             valid_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] burst_len_i,
  input  logic [SYM_W-1:0] flip_mask_i,
  input  logic [7:0]       thresh_i,
  input  logic             clr_i,
  output logic [SYM_W-1:0] sym_o,
  output logic             valid_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_count_o
);

  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W:0]   pos_inc;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             valid_q, err_q, err_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             per_hit, rnd_hit, hit;

  always_comb begin
    per_hit = 1'b0;
    if (period_i != '0 && burst_len_i != '0) begin
      // Burst covering the whole period would underflow the window start, so hit everything.
      if (burst_len_i >= period_i) per_hit = 1'b1;
      else if (pos_q >= period_i - burst_len_i) per_hit = 1'b1;
    end
  end

`ifdef INJ_RANDOM_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign rnd_hit = lfsr_q[7:0] < thresh_i;

  always_comb begin
    lfsr_d = lfsr_q;
    if (valid_i) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= LFSR_SEED;
    else      lfsr_q <= lfsr_d;
  end

  always_comb begin
    hit = 1'b0;
    unique case (mode_i)
      2'b00: hit = 1'b0;
      2'b01: hit = per_hit;
      2'b10: hit = rnd_hit;
      2'b11: hit = per_hit | rnd_hit;
      default: hit = 1'b0;
    endcase
  end
`else
  logic unused_rnd;

  assign rnd_hit    = 1'b0;
  assign unused_rnd = ^{thresh_i, mode_i[1], rnd_hit, LFSR_SEED};
  // Without the LFSR, mode 10 collapses to bypass and 11 to periodic.
  assign hit        = mode_i[0] & per_hit;
`endif

  assign pos_inc = {1'b0, pos_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    pos_d = pos_q;
    sym_d = sym_q;
    err_d = 1'b0;
    cnt_d = cnt_q;
    if (valid_i) begin
      // Also wraps a pos left beyond a freshly shortened period.
      if (period_i == '0 || pos_inc >= {1'b0, period_i}) pos_d = '0;
      else pos_d = pos_inc[CNT_W-1:0];
      sym_d = sym_i ^ (hit ? flip_mask_i : '0);
      err_d = hit;
      if (hit && !(&cnt_q)) cnt_d = cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end
    if (clr_i) begin
      pos_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q   <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pos_q   <= pos_d;
      sym_q   <= sym_d;
      valid_q <= valid_i;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sym_o       = sym_q;
  assign valid_o     = valid_q;
  assign err_o       = err_q;
  assign err_count_o = cnt_q;

endmodule
